mem_arbiter: RTL
================

# mem_arbiter

Two-requester, single-port memory arbiter between the RV32I `processor` memory port (requester 0) and a second bus master (requester 1, e.g. program loader or DMA) on one shared memory. It grants one transfer per cycle with bounded-burst fairness. It drives the shared memory port and routes read data back to the requester that issued the read, after a fixed memory read latency.

## Interface

Parameters:

- `RD_LAT`, default 1: memory read latency in cycles from `mem_rstrb_o` to valid `mem_rdata_i`. Legal values are 1..4.
- `MAX_BURST`, default 4: maximum consecutive grants to one requester while the other requester waits. Legal values are 1..15.

Ports:

- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `mX_req_i`  in  1  requester X (X = 0, 1) presents a transfer this cycle.
- `mX_addr_i`  in  32  word-aligned byte address.
- `mX_rstrb_i`  in  1  read strobe.
- `mX_wmask_i`  in  4  byte write mask; 0 means no write.
- `mX_wdata_i`  in  32  write data.
- `mX_gnt_o`  out  1  transfer accepted this cycle (combinational).
- `mX_rvalid_o`  out  1  read data for requester X is valid this cycle.
- `mX_rdata_o`  out  32  read data; carries `mem_rdata_i` unconditionally.
- `mem_addr_o`  out  32  shared memory address.
- `mem_rstrb_o`  out  1  shared memory read strobe.
- `mem_wmask_o`  out  4  shared memory write mask.
- `mem_wdata_o`  out  32  shared memory write data.
- `mem_rdata_i`  in  32  shared memory read data.

## Operation

- A transfer is a cycle with `mX_req_i`=1. It is a read if `mX_rstrb_i`=1, a write if `mX_wmask_i`≠0, or both if both are set (memory semantics apply). A request with neither set is granted and has no memory effect.
- A requester holds `req` and its payload stable until `gnt` is seen. A requester may drop `req` without a grant; this is legal.
- Registered state:
  - `owner_r`: last granted requester; reset 1, so requester 0 wins the first tie.
  - `run_cnt_r` (4 bits): consecutive grants to `owner_r`; reset 0.
  - Read-tag pipeline: `RD_LAT` stages of {valid, id}; reset all invalid.
- Arbitration, evaluated each cycle:
  - Neither requesting: no grant. `run_cnt_r` goes to 0; `owner_r` is unchanged.
  - Only one requesting: that one is granted.
  - Both requesting:
    - If `owner_r` is requesting and `run_cnt_r` < `MAX_BURST`, grant `owner_r`.
    - Otherwise grant the other requester.
- On a grant to requester g:
  - If g = `owner_r` and the previous cycle had a grant, `run_cnt_r` increments, saturating at 15.
  - Otherwise `owner_r` becomes g and `run_cnt_r` becomes 1.
- At most one `mX_gnt_o` is high in any cycle. No grant is ever issued while `rst_ni`=0.
- Memory port:
  - On a grant, it mirrors the granted requester's addr/rstrb/wmask/wdata.
  - With no grant, `mem_rstrb_o`=0, `mem_wmask_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0.
- Read return:
  - A granted read pushes {1, g} into tag stage 0. Any other cycle pushes {0, -}.
  - The last stage drives `mX_rvalid_o` = valid & (id == X).
- Writes never produce `rvalid`.

## Timing

- Grant has zero latency: `gnt` is combinational from `req` and registered state in the same cycle.
- A read granted in cycle t gives `rvalid` in cycle t+`RD_LAT`, with `rdata` = `mem_rdata_i` of that cycle.
- Back-to-back reads from alternating requesters are supported at one per cycle. Return order equals grant order.
- A write granted in cycle t is presented to memory in cycle t.
- Reset (`rst_ni`=0 at an edge):
  - All registers return to reset values.
  - In-flight read tags are discarded, so no `rvalid` follows for reads granted before reset.
  - Outputs in reset cycles: `gnt`=0, `mem_rstrb_o`=0, `mem_wmask_o`=0, `rvalid`=0.
- Worst-case wait for a continuously requesting master is `MAX_BURST` cycles.

## Test plan

- Reset, then both requesters issue reads every cycle, `RD_LAT`=1, `MAX_BURST`=4 → grant sequence is 0,0,0,0,1,1,1,1,0,…. Each `mX_rvalid_o` appears exactly one cycle after its grant, with the matching `mem_rdata_i`.
- Only m1 requests writes for 10 cycles (addr 0x100+4k, wmask 4'b1111) → m1 is granted every cycle. The memory port mirrors each payload, and no `rvalid` occurs.
- `RD_LAT`=3: m0 reads 0x0, m1 reads 0x4, m0 reads 0x8 on consecutive cycles → `rvalid` arrives at t+3, t+4, t+5 for m0, m1, m0 respectively, and never for the wrong requester.
- Both requesting, m0 owner with `run_cnt_r`=2, then m0 drops `req` for one cycle → m1 is granted immediately and becomes owner with `run_cnt_r`=1. When m0 re-requests, it waits until m1 has had 4 grants.
- Assert `rst_ni`=0 one cycle after granting an m0 read with `RD_LAT`=2 → no `m0_rvalid_o` ever returns for that read. After release, the first tie is granted to m0.
- Idle gap: m0 granted 3 times, then 2 idle cycles, then both request → m0 is granted (owner stays m0, `run_cnt_r` was reset to 0), and the burst restarts at 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester, single-port memory arbiter. Requester 0 is the processor
// memory port and requester 1 is a second bus master such as a loader or DMA.
// One transfer is granted per cycle, and bounded-burst fairness caps how many
// consecutive grants one side can take while the other side waits.
// Read data returns to the requester that issued the read, RD_LAT cycles
// after the memory strobe, through a small tag pipeline.

module mem_arbiter #(
    parameter int RD_LAT    = 1,   // memory read latency, legal 1..4
    parameter int MAX_BURST = 4    // max consecutive grants while other waits, legal 1..15
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_rstrb_i,
    input  logic [3:0]  m0_wmask_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_rstrb_i,
    input  logic [3:0]  m1_wmask_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_rstrb_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
    localparam logic [3:0] RUN_SAT_C   = 4'd15;
    localparam logic       ID_M0_C     = 1'b0;

    // Arbitration state
    logic       owner_r;          // last granted requester
    logic [3:0] run_cnt_r;        // consecutive grants to owner_r, 0 after an idle cycle
    logic       gnt_seen_r;       // a grant has been issued since reset

    logic       owner_next_s;
    logic [3:0] run_cnt_next_s;
    logic       gnt_seen_next_s;

    logic       gnt0_s;
    logic       gnt1_s;
    logic       gnt_any_s;
    logic       gnt_id_s;
    logic       rd_push_s;

    // Read-tag pipeline: bit i is stage i, stage RD_LAT-1 is the output stage
    logic [RD_LAT-1:0] tag_vld_r;
    logic [RD_LAT-1:0] tag_id_r;

    // Grant decision: zero-latency, from requests and registered state.
    // owner_r resets to 1, but the first tie after reset must still go to
    // requester 0, so ties before any grant are forced to requester 0.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (!rst_ni) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else if (m0_req_i && m1_req_i) begin
            if (!gnt_seen_r) begin
                gnt0_s = 1'b1;
                gnt1_s = 1'b0;
            end else if (run_cnt_r < MAX_BURST_C) begin
                gnt0_s = ~owner_r;
                gnt1_s = owner_r;
            end else begin
                gnt0_s = owner_r;
                gnt1_s = ~owner_r;
            end
        end else begin
            gnt0_s = m0_req_i;
            gnt1_s = m1_req_i;
        end
    end

    assign gnt_any_s = gnt0_s | gnt1_s;
    assign gnt_id_s  = gnt1_s;
    assign m0_gnt_o  = gnt0_s;
    assign m1_gnt_o  = gnt1_s;

    // Memory port mux: mirror the granted payload, drive zeros when idle
    always_comb begin
        mem_addr_o  = 32'h0000_0000;
        mem_rstrb_o = 1'b0;
        mem_wmask_o = 4'b0000;
        mem_wdata_o = 32'h0000_0000;
        case ({gnt1_s, gnt0_s})
            2'b01: begin
                mem_addr_o  = m0_addr_i;
                mem_rstrb_o = m0_rstrb_i;
                mem_wmask_o = m0_wmask_i;
                mem_wdata_o = m0_wdata_i;
            end
            2'b10: begin
                mem_addr_o  = m1_addr_i;
                mem_rstrb_o = m1_rstrb_i;
                mem_wmask_o = m1_wmask_i;
                mem_wdata_o = m1_wdata_i;
            end
            default: begin
                mem_addr_o  = 32'h0000_0000;
                mem_rstrb_o = 1'b0;
                mem_wmask_o = 4'b0000;
                mem_wdata_o = 32'h0000_0000;
            end
        endcase
    end

    assign rd_push_s = gnt_any_s & mem_rstrb_o;

    // Next ownership/burst state. A nonzero run count means the previous
    // cycle carried a grant, so only then does a repeat grant extend the burst.
    always_comb begin
        owner_next_s    = owner_r;
        run_cnt_next_s  = run_cnt_r;
        gnt_seen_next_s = gnt_seen_r;
        if (gnt_any_s) begin
            gnt_seen_next_s = 1'b1;
            if ((gnt_id_s == owner_r) && (run_cnt_r != 4'd0)) begin
                owner_next_s = owner_r;
                if (run_cnt_r != RUN_SAT_C) begin
                    run_cnt_next_s = run_cnt_r + 4'd1;
                end else begin
                    run_cnt_next_s = run_cnt_r;
                end
            end else begin
                owner_next_s   = gnt_id_s;
                run_cnt_next_s = 4'd1;
            end
        end else begin
            run_cnt_next_s = 4'd0;
        end
    end

    // Arbitration state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            owner_r    <= 1'b1;
            run_cnt_r  <= 4'd0;
            gnt_seen_r <= 1'b0;
        end else begin
            owner_r    <= owner_next_s;
            run_cnt_r  <= run_cnt_next_s;
            gnt_seen_r <= gnt_seen_next_s;
        end
    end

    // Read-tag shift pipeline; reset discards every in-flight read
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_vld_r <= '0;
            tag_id_r  <= '0;
        end else begin
            tag_vld_r[0] <= rd_push_s;
            tag_id_r[0]  <= gnt_id_s;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_r[i] <= tag_vld_r[i-1];
                tag_id_r[i]  <= tag_id_r[i-1];
            end
        end
    end

    assign m0_rvalid_o = rst_ni & tag_vld_r[RD_LAT-1] & (tag_id_r[RD_LAT-1] == ID_M0_C);
    assign m1_rvalid_o = rst_ni & tag_vld_r[RD_LAT-1] & (tag_id_r[RD_LAT-1] != ID_M0_C);
    assign m0_rdata_o  = mem_rdata_i;
    assign m1_rdata_o  = mem_rdata_i;

    mem_arbiter_chk u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .gnt0        (gnt0_s),
        .gnt1        (gnt1_s),
        .rvalid0     (m0_rvalid_o),
        .rvalid1     (m1_rvalid_o),
        .mem_rstrb   (mem_rstrb_o),
        .mem_wmask   (mem_wmask_o)
    );

endmodule

// mem_arbiter_chk
// Structural invariants of the arbiter outputs.
module mem_arbiter_chk (
    input logic       clk_i,
    input logic       rst_ni,
    input logic       gnt0,
    input logic       gnt1,
    input logic       rvalid0,
    input logic       rvalid1,
    input logic       mem_rstrb,
    input logic [3:0] mem_wmask
);

    // Never two grants in one cycle
    a_one_gnt: assert property (@(posedge clk_i) !(gnt0 && gnt1));

    // Never two read returns in one cycle
    a_one_rvalid: assert property (@(posedge clk_i) !(rvalid0 && rvalid1));

    // Reset cycles are quiet on grants, memory strobes and returns
    a_rst_quiet: assert property (@(posedge clk_i)
        !rst_ni |-> !(gnt0 || gnt1 || rvalid0 || rvalid1 || mem_rstrb || (mem_wmask != 4'b0000)));

endmodule
